// File: rtl/pc_stack_ctrl_pkg.sv
// pc_stack_ctrl_pkg: shared widths, jump condition codes, status-register bit indices and condition helper
package pc_stack_ctrl_pkg;
  localparam int ADDR_W = 12;
  localparam int SR_OVF = 0;
  localparam int SR_STOVF = 1;
  localparam int SR_NZ = 2;
  localparam int SR_Z = 3;
  typedef enum logic [1:0] {
    JMP_COND_ALWAYS = 2'b00,
    JMP_COND_Z      = 2'b01,
    JMP_COND_NZ     = 2'b10,
    JMP_COND_OVF    = 2'b11
  } jmp_cond_e;
  function automatic logic cond_met(input logic [1:0] c, input logic [7:0] sr);
    return c == JMP_COND_ALWAYS ? 1'b1 :
           c == JMP_COND_Z      ? sr[SR_Z] :
           c == JMP_COND_NZ     ? sr[SR_NZ] : sr[SR_OVF];
  endfunction
endpackage

// File: rtl/pc_stack_ctrl_call_stack.sv
// call_stack: return-address LIFO (clk, reset_, push, pop, data_in -> top, full, empty, depth)
module call_stack
  import pc_stack_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        data_in,
  output logic [ADDR_W-1:0]        top,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   depth
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PW:0]       r_sp;
  logic [PW-1:0]     w_top_idx;
  assign w_top_idx = r_sp[PW-1:0] - PW'(1);
  assign top = r_mem[w_top_idx];
  assign full = r_sp == (PW+1)'(DEPTH);
  assign empty = r_sp == '0;
  assign depth = r_sp;
  always_ff @(posedge clk) begin
    if (!reset_) r_sp <= '0;
    else if (push && !full) r_sp <= r_sp + 1'b1;
    else if (pop && !empty) r_sp <= r_sp - 1'b1;
  end
  always_ff @(posedge clk)
    if (push && !full) r_mem[r_sp[PW-1:0]] <= data_in;
endmodule

// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl: PC generator with conditional jumps and CALL/RET stack (fetch address, flush pulse, sticky stack flags, depth)
module pc_stack_ctrl
  import pc_stack_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 12'h000,
  parameter int                STACK_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset_,
  input  logic                           fetch_en,
  input  logic                           stall,
  input  logic                           jmp_vld,
  input  logic [1:0]                     jmp_cond,
  input  logic                           call_vld,
  input  logic                           ret_vld,
  input  logic [ADDR_W-1:0]              tgt_addr,
  input  logic [ADDR_W-1:0]              ret_addr,
  input  logic [7:0]                     sr,
  output logic [ADDR_W-1:0]              i_mem_addr,
  output logic                           i_mem_en,
  output logic [ADDR_W-1:0]              next_addr,
  output logic                           flush,
  output logic                           stk_ovf,
  output logic                           stk_udf,
  output logic [$clog2(STACK_DEPTH):0]   stk_depth
);
  logic [ADDR_W-1:0] r_pc, w_top, w_pc_nxt;
  logic r_flush, r_ovf, r_udf;
  logic w_full, w_empty, w_ret_take, w_call_take, w_jmp_take, w_redir, w_seq;
  // lower-priority requests are dropped whenever a higher one is present, even if it fails
  assign w_ret_take = ret_vld && !w_empty;
  assign w_call_take = !ret_vld && call_vld && !w_full;
  assign w_jmp_take = !ret_vld && !call_vld && jmp_vld && cond_met(jmp_cond, sr);
  assign w_redir = w_ret_take || w_call_take || w_jmp_take;
  assign w_seq = fetch_en && !stall;
  assign w_pc_nxt = w_ret_take ? w_top :
                    (w_call_take || w_jmp_take) ? tgt_addr :
                    w_seq ? r_pc + 1'b1 : r_pc;
  call_stack #(.DEPTH(STACK_DEPTH)) u_stk (
    .clk(clk), .reset_(reset_), .push(w_call_take), .pop(w_ret_take),
    .data_in(ret_addr), .top(w_top), .full(w_full), .empty(w_empty), .depth(stk_depth)
  );
  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_pc <= RESET_VECTOR;
      r_flush <= 1'b0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      r_flush <= w_redir;
      r_ovf <= r_ovf || (!ret_vld && call_vld && w_full);
      r_udf <= r_udf || (ret_vld && w_empty);
    end
  end
  assign i_mem_addr = r_pc;
  assign next_addr = r_pc + 1'b1;
  assign i_mem_en = fetch_en && !stall && reset_;
  assign flush = r_flush;
  assign stk_ovf = r_ovf;
  assign stk_udf = r_udf;
endmodule

// File: tb/tb_pc_stack_ctrl.sv
// tb_pc_stack_ctrl: directed plan plus random traffic checked against a queue-based reference model
module tb_pc_stack_ctrl;
  localparam logic [11:0] RV = 12'h010;
  localparam int SD = 8;
  logic clk = 0, reset_ = 0, fetch_en = 0, stall = 0, jmp_vld = 0, call_vld = 0, ret_vld = 0;
  logic [1:0] jmp_cond = 0;
  logic [11:0] tgt_addr = 0, ret_addr = 0, i_mem_addr, next_addr;
  logic [7:0] sr = 0;
  logic i_mem_en, flush, stk_ovf, stk_udf;
  logic [3:0] stk_depth;
  int total = 0, bad = 0;
  int m_pc, m_fl, m_ovf, m_udf;
  int m_q[$];
  pc_stack_ctrl #(.RESET_VECTOR(RV), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset_(reset_), .fetch_en(fetch_en), .stall(stall), .jmp_vld(jmp_vld),
    .jmp_cond(jmp_cond), .call_vld(call_vld), .ret_vld(ret_vld), .tgt_addr(tgt_addr),
    .ret_addr(ret_addr), .sr(sr), .i_mem_addr(i_mem_addr), .i_mem_en(i_mem_en),
    .next_addr(next_addr), .flush(flush), .stk_ovf(stk_ovf), .stk_udf(stk_udf), .stk_depth(stk_depth)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rs, input logic fe, input logic st, input logic jv, input logic [1:0] jc,
                      input logic cv, input logic rv, input logic [11:0] tg, input logic [11:0] ra, input logic [7:0] s);
    logic red, c;
    int npc;
    reset_ = rs; fetch_en = fe; stall = st; jmp_vld = jv; jmp_cond = jc;
    call_vld = cv; ret_vld = rv; tgt_addr = tg; ret_addr = ra; sr = s;
    #1;
    chk("i_mem_en", i_mem_en, fe & ~st & rs);
    @(posedge clk);
    if (!rs) begin
      m_pc = RV; m_q.delete(); m_fl = 0; m_ovf = 0; m_udf = 0;
    end else begin
      red = 0;
      npc = (fe && !st) ? (m_pc + 1) % 4096 : m_pc;
      if (rv) begin
        if (m_q.size() > 0) begin npc = m_q.pop_back(); red = 1; end
        else m_udf = 1;
      end else if (cv) begin
        if (m_q.size() < SD) begin m_q.push_back(ra); npc = tg; red = 1; end
        else m_ovf = 1;
      end else if (jv) begin
        c = jc == 0 ? 1'b1 : jc == 1 ? s[3] : jc == 2 ? s[2] : s[0];
        if (c) begin npc = tg; red = 1; end
      end
      m_pc = npc; m_fl = red;
    end
    #1;
    chk("pc", i_mem_addr, m_pc);
    chk("next_addr", next_addr, (m_pc + 1) % 4096);
    chk("flush", flush, m_fl);
    chk("stk_ovf", stk_ovf, m_ovf);
    chk("stk_udf", stk_udf, m_udf);
    chk("stk_depth", stk_depth, m_q.size());
  endtask
  task automatic seq(input int n, input logic fe, input logic st);
    for (int i = 0; i < n; i++) step(1, fe, st, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    #1;
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", i_mem_addr, 12'h010);
    seq(4, 1, 0);
    chk("seq_pc", i_mem_addr, 12'h014);
    step(1, 0, 0, 1, 0, 0, 0, 12'hFFE, 0, 0);
    seq(1, 1, 0);
    chk("wrap_next", next_addr, 12'h000);
    seq(2, 1, 0);
    chk("wrap_pc", i_mem_addr, 12'h001);
    step(1, 1, 0, 1, 1, 0, 0, 12'h200, 0, 8'h00);
    step(1, 1, 0, 1, 1, 0, 0, 12'h200, 0, 8'h08);
    chk("jz_taken", i_mem_addr, 12'h200);
    seq(1, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0, 12'h300, 12'h041, 0);
    seq(1, 1, 0);
    step(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("ret_pc", i_mem_addr, 12'h041);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0, 1, 0, 12'h400 + i, 12'h500 + i, 0);
    chk("ovf_set", stk_ovf, 1);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("udf_set", stk_udf, 1);
    step(1, 1, 1, 1, 0, 0, 0, 12'h123, 0, 0);
    chk("stall_jmp", i_mem_addr, 12'h123);
    seq(3, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 1, 0, 12'h600, 12'h700 + i, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("midreset_depth", stk_depth, 0);
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, 2'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, 12'($urandom), 12'($urandom), 8'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
